// File: rtl/alu_arb_pkg.sv
// Shared types, command codes and helpers for the ALU request arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic cout;
        logic oflow;
        logic g;
        logic e;
        logic l;
        logic err;
    } alu_flags_t;

    localparam int CMD_W_MAX = 8;
    localparam logic [CMD_W_MAX-1:0] CMD_MUL_INC = 8'd9;
    localparam logic [CMD_W_MAX-1:0] CMD_MUL_SHL = 8'd10;

    // Multiplies only exist in arithmetic mode; logical commands 9/10 take the short latency.
    function automatic logic is_mul(input logic mode, input logic [CMD_W_MAX-1:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational requester arbiter: one-hot grant plus encoded winner id.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module alu_rr_arbiter
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
)
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = IDW'(i);
            end
        end
    end
`else
    // Scan from the farthest slot back toward the pointer so the closest requester wins last.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                grant                           = '0;
                grant[(int'(ptr) + k) % NREQ]   = 1'b1;
                grant_id                        = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NREQ requesters, one operation in flight, operands issued in a single cycle.
// Build option ALU_ARB_FIXED_PRIO_EN: fixed-priority arbitration, pointer never advances.
//
// state | meaning
// IDLE  | offer grant, accept one request and latch its operands
// ISSUE | drive both operands valid to the ALU for one cycle, load latency counter
// WAIT  | count down ALU latency, capture result and flags at count 1
// RESP  | one-cycle response strobe
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CWIDTH  = 4,
    parameter int NREQ    = 4,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 3,
    localparam int IDW    = $clog2(NREQ)
)
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_opa,
    input  logic [NREQ*WIDTH-1:0]  req_opb,
    input  logic [NREQ*CWIDTH-1:0] req_cmd,
    input  logic [NREQ-1:0]        req_mode,
    input  logic [NREQ-1:0]        req_cin,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [2*WIDTH-1:0]     rsp_res,
    output logic [5:0]             rsp_flags,
    output logic [1:0]             alu_inp_valid,
    output logic                   alu_ce,
    output logic [WIDTH-1:0]       alu_opa,
    output logic [WIDTH-1:0]       alu_opb,
    output logic [CWIDTH-1:0]      alu_cmd,
    output logic                   alu_mode,
    output logic                   alu_cin,
    input  logic [2*WIDTH-1:0]     alu_res,
    input  logic                   alu_cout,
    input  logic                   alu_oflow,
    input  logic                   alu_g,
    input  logic                   alu_e,
    input  logic                   alu_l,
    input  logic                   alu_err
);

    localparam int CNTW = $clog2(MUL_LAT + 1);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [WIDTH-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic [CWIDTH-1:0]   cmd_q, cmd_d;
    logic                mode_q, mode_d;
    logic                cin_q, cin_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]  rsp_res_q, rsp_res_d;
    alu_flags_t          rsp_flags_q, rsp_flags_d;
    logic                alu_ce_q, alu_ce_d;

    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic                idle;
    logic                accept;
    logic [CMD_W_MAX-1:0] cmd_ext;
    alu_flags_t          alu_flags;

    alu_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grant is masked during reset so no handshake can complete while RST is high.
    assign idle      = (state_q == IDLE) && !RST;
    assign accept    = idle && (|grant);
    assign cmd_ext   = CMD_W_MAX'(cmd_q);
    assign alu_flags = {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        cnt_d       = cnt_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        alu_ce_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d   = grant_id;
                    opa_d  = req_opa[grant_id*WIDTH +: WIDTH];
                    opb_d  = req_opb[grant_id*WIDTH +: WIDTH];
                    cmd_d  = req_cmd[grant_id*CWIDTH +: CWIDTH];
                    mode_d = req_mode[grant_id];
                    cin_d  = req_cin[grant_id];
`ifndef ALU_ARB_FIXED_PRIO_EN
                    ptr_d  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = is_mul(mode_q, cmd_ext) ? CNTW'(MUL_LAT) : CNTW'(LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNTW'(1)) begin
                    rsp_res_d   = alu_res;
                    rsp_flags_d = alu_flags;
                    rsp_id_d    = id_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            alu_ce_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            cnt_q       <= cnt_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            alu_ce_q    <= alu_ce_d;
        end
    end

    assign req_ready     = idle ? grant : '0;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = rsp_id_q;
    assign rsp_res       = rsp_res_q;
    assign rsp_flags     = rsp_flags_q;
    assign alu_inp_valid = (state_q == ISSUE) ? 2'b11 : 2'b00;
    assign alu_ce        = alu_ce_q;
    assign alu_opa       = opa_q;
    assign alu_opb       = opb_q;
    assign alu_cmd       = cmd_q;
    assign alu_mode      = mode_q;
    assign alu_cin       = cin_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed vector table, hand sequences, randomized run vs. a reference model.
module tb_alu_req_arbiter;

    localparam int WIDTH = 8, CWIDTH = 4, NREQ = 4, LAT = 1, MUL_LAT = 3;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [NREQ-1:0]        req_valid = '0, req_ready, req_mode = '0, req_cin = '0;
    logic [NREQ*WIDTH-1:0]  req_opa = '0, req_opb = '0;
    logic [NREQ*CWIDTH-1:0] req_cmd = '0;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [15:0]            rsp_res;
    logic [5:0]             rsp_flags;
    logic [1:0]             alu_inp_valid;
    logic                   alu_ce, alu_mode, alu_cin;
    logic [7:0]             alu_opa, alu_opb;
    logic [3:0]             alu_cmd;
    logic [15:0]            alu_res;
    logic                   alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu_req_arbiter #(.WIDTH(WIDTH), .CWIDTH(CWIDTH), .NREQ(NREQ), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .alu_inp_valid(alu_inp_valid), .alu_ce(alu_ce),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
        .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow),
        .alu_g(alu_g), .alu_e(alu_e), .alu_l(alu_l), .alu_err(alu_err)
    );

    // Behavioural ALU: returns {cout,oflow,g,e,l,err, res}.
    function automatic logic [21:0] alu_fn(input logic m, input logic [3:0] c,
                                           input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [15:0] r;
        logic [5:0]  f;
        logic [8:0]  s;
        r = '0; f = '0; s = '0;
        if (m) begin
            case (c)
                4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = {7'd0, s}; f[5] = s[8]; end
                4'd1:  begin r = {8'd0, a - b}; f[4] = (a < b); end
                4'd2:  begin s = {1'b0, a} + {1'b0, b} + {8'd0, ci}; r = {7'd0, s}; f[5] = s[8]; end
                4'd8:  begin f[3] = (a > b); f[2] = (a == b); f[1] = (a < b); end
                4'd9:  r = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
                4'd10: r = ({8'd0, a} << 1) * {8'd0, b};
                default: f[0] = 1'b1;
            endcase
        end else begin
            case (c)
                4'd0: r = {8'd0, a & b};
                4'd1: r = {8'd0, a | b};
                4'd2: r = {8'd0, a ^ b};
                default: f[0] = 1'b1;
            endcase
        end
        return {f, r};
    endfunction

    function automatic int op_lat(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? MUL_LAT : LAT;
    endfunction

    // ALU pin model: result is only visible once its latency has elapsed, garbage before.
    logic [21:0] alu_pend = '0;
    int          alu_cnt = 0;
    always @(posedge CLK) begin
        if (alu_inp_valid == 2'b11) begin
            alu_pend <= alu_fn(alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin);
            alu_cnt  <= op_lat(alu_mode, alu_cmd) - 1;
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
        end
    end
    always_comb begin
        {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err, alu_res} =
            (alu_cnt == 0) ? alu_pend : {6'h3F, 16'hDEAD};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic m, input logic [3:0] c,
                           input logic [7:0] a, input logic [7:0] b, input logic ci);
        req_mode[i]             = m;
        req_cmd[i*CWIDTH +: 4]  = c;
        req_opa[i*WIDTH +: 8]   = a;
        req_opb[i*WIDTH +: 8]   = b;
        req_cin[i]              = ci;
    endtask

    task automatic new_rand_req(input int i);
        logic [3:0] cmds [8];
        cmds = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10, 4'd5, 4'd3};
        set_req(i, 1'($urandom), cmds[$urandom_range(0, 7)], 8'($urandom), 8'($urandom), 1'($urandom));
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req_valid = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] v, input int p);
        int i;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            i = k;
`else
            i = (p + k) % NREQ;
`endif
            if (v[i]) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    typedef struct {
        int         id;
        logic       mode;
        logic [3:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [15:0] res;
        logic [5:0] flags;
        int         lat;
    } vec_t;

    vec_t tbl [8];
    int   exp_g [5];

    initial begin
        vec_t t;
        int lat, n11, ng, nr, nrsp, first_k;
        int gq [5];
        int rq [5];
        int ptr_m, next_free, issue_c, rsp_c, L, id;
        logic [NREQ-1:0] exp_rdy;
        logic [21:0] exp_fr;
        logic [7:0]  ea, eb;
        logic [3:0]  ec;
        logic [1:0]  eid;

        tbl[0] = '{0, 1'b1, 4'd0,  8'h0F, 8'h01, 1'b0, 16'h0010, 6'b000000, 3};
        tbl[1] = '{1, 1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 16'd20,   6'b000000, 5};
        tbl[2] = '{2, 1'b1, 4'd8,  8'h55, 8'h55, 1'b0, 16'h0000, 6'b000100, 3};
        tbl[3] = '{3, 1'b1, 4'd10, 8'h05, 8'h03, 1'b0, 16'd30,   6'b000000, 5};
        tbl[4] = '{0, 1'b0, 4'd9,  8'hFF, 8'h0F, 1'b0, 16'h0000, 6'b000001, 3};
        tbl[5] = '{1, 1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 16'h0100, 6'b100000, 3};
        tbl[6] = '{2, 1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 16'h0030, 6'b000000, 3};
        tbl[7] = '{3, 1'b1, 4'd2,  8'h10, 8'h20, 1'b1, 16'h0031, 6'b000000, 3};
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif

        // Reset values
        do_reset();
        @(negedge CLK);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_res", rsp_res, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_inp_valid", alu_inp_valid, 0);
        chk("rst_alu_ops", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}, 0);
        chk("rst_alu_ce", alu_ce, 1);
        chk("rst_req_ready", req_ready, 0);

        // Directed vector table, one requester at a time
        for (int v = 0; v < 8; v++) begin
            t = tbl[v];
            @(posedge CLK); #1;
            set_req(t.id, t.mode, t.cmd, t.a, t.b, t.ci);
            req_valid = NREQ'(1) << t.id;
            @(negedge CLK);
            chk("vec_grant", req_ready, NREQ'(1) << t.id);
            @(posedge CLK); #1 req_valid = '0;
            lat = 0; n11 = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge CLK);
                if (alu_inp_valid == 2'b11) n11++;
                if (rsp_valid) begin lat = k; break; end
            end
            chk("vec_latency", lat, t.lat);
            chk("vec_rsp_id", rsp_id, t.id);
            chk("vec_rsp_res", rsp_res, t.res);
            chk("vec_rsp_flags", rsp_flags, t.flags);
            chk("vec_issue_cycles", n11, 1);
            @(negedge CLK);
            chk("vec_rsp_pulse", rsp_valid, 0);
            chk("vec_rsp_hold", rsp_res, t.res);
        end

        // All requesters valid continuously
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'd0, 8'(i + 1), 8'h10, 1'b0);
        req_valid = '1;
        gq = '{-1, -1, -1, -1, -1};
        rq = '{-1, -1, -1, -1, -1};
        ng = 0; nr = 0;
        for (int c = 0; c < 200 && nr < 5; c++) begin
            @(negedge CLK);
            if (req_ready != '0 && ng < 5) begin
                chk("rr_onehot", $countones(req_ready), 1);
                gq[ng] = oh_idx(req_ready);
                ng++;
            end
            if (rsp_valid && nr < 5) begin
                rq[nr] = int'(rsp_id);
                chk("rr_rsp_res", rsp_res, 16'(exp_g[nr] + 1 + 16));
                nr++;
            end
        end
        chk("rr_rsp_count", nr, 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant_order", gq[i], exp_g[i]);
            chk("rr_rsp_id_order", rq[i], exp_g[i]);
        end
        @(posedge CLK); #1 req_valid = '0;

        // Reset during WAIT of a multiply
        do_reset();
        @(posedge CLK); #1;
        set_req(1, 1'b1, 4'd9, 8'h03, 8'h04, 1'b0);
        req_valid = 4'b0010;
        @(negedge CLK);
        chk("rstw_grant", req_ready, 4'b0010);
        @(posedge CLK); #1 req_valid = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        set_req(0, 1'b1, 4'd0, 8'h01, 8'h02, 1'b0);
        req_valid = '1;
        #1;
        chk("rstw_ready_in_rst", req_ready, 0);
        chk("rstw_rsp_in_rst", rsp_valid, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("rstw_ready_in_rst", req_ready, 0);
            chk("rstw_rsp_in_rst", rsp_valid, 0);
        end
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("rstw_first_grant", req_ready, 4'b0001);
        @(posedge CLK); #1 req_valid = '0;
        nrsp = 0; first_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                nrsp++;
                if (first_k == 0) begin
                    first_k = k;
                    chk("rstw_rsp_id", rsp_id, 0);
                    chk("rstw_rsp_res", rsp_res, 16'h0003);
                end
            end
        end
        chk("rstw_rsp_count", nrsp, 1);
        chk("rstw_rsp_latency", first_k, LAT + 2);

        // Randomized run against the reference model
        do_reset();
        ptr_m = 0; next_free = 0; issue_c = -10; rsp_c = -10;
        ea = '0; eb = '0; ec = '0; eid = '0; exp_fr = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            exp_rdy = (c >= next_free) ? model_pick(req_valid, ptr_m) : '0;
            chk("rnd_ready", req_ready, exp_rdy);
            chk("rnd_rsp_valid", rsp_valid, 32'(c == rsp_c));
            if (c == rsp_c) begin
                chk("rnd_rsp_id", rsp_id, eid);
                chk("rnd_rsp_res", rsp_res, exp_fr[15:0]);
                chk("rnd_rsp_flags", rsp_flags, exp_fr[21:16]);
            end
            chk("rnd_inp_valid", alu_inp_valid, (c == issue_c) ? 2'b11 : 2'b00);
            if (c == issue_c) chk("rnd_alu_operands", {alu_opa, alu_opb, alu_cmd}, {ea, eb, ec});
            chk("rnd_alu_ce", alu_ce, 1);
            if (exp_rdy != '0) begin
                id     = oh_idx(exp_rdy);
                eid    = 2'(id);
                ea     = req_opa[id*WIDTH +: 8];
                eb     = req_opb[id*WIDTH +: 8];
                ec     = req_cmd[id*CWIDTH +: 4];
                exp_fr = alu_fn(req_mode[id], ec, ea, eb, req_cin[id]);
                L      = op_lat(req_mode[id], ec);
                issue_c   = c + 1;
                rsp_c     = c + L + 2;
                next_free = c + L + 3;
`ifndef ALU_ARB_FIXED_PRIO_EN
                ptr_m = (id + 1) % NREQ;
`endif
            end
            @(posedge CLK); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) begin
                    if ($urandom_range(0, 1) == 1) new_rand_req(i);
                    else req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    new_rand_req(i);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
